// File: rtl/decode_stage.sv
// decode_stage: register file, write-back select with load extension, immediate generation,
//   load-use stall and flush into one registered valid/ready slot. Latency: 1 cycle in->out.
// Backpressure: slot holds while out_valid & ~out_ready; in_ready low on stall, hold, or reset.
// Optional: DECODE_BYPASS_EN forwards the same-cycle write-back into operand and ecall reads.
module decode_stage #(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [31:0]     in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_inst,
    output logic [31:0]     out_pc,
    output logic [XLEN-1:0] out_rdata1,
    output logic [XLEN-1:0] out_rdata2,
    output logic [XLEN-1:0] out_imm,
    output logic [4:0]      out_rd,
    input  logic            flush,
    input  logic            ex_is_load,
    input  logic [4:0]      ex_rd,
    input  logic            wb_en,
    input  logic [4:0]      wb_rd,
    input  logic [1:0]      wb_src,
    input  logic [2:0]      wb_funct3,
    input  logic [1:0]      wb_byte_off,
    input  logic [XLEN-1:0] wb_alu,
    input  logic [XLEN-1:0] wb_mem,
    input  logic [XLEN-1:0] wb_pc4,
    input  logic [XLEN-1:0] wb_imm,
    output logic [XLEN-1:0] ecall_code,
    output logic [XLEN-1:0] ecall_a0_data
);
    localparam int AW = $clog2(NREG);

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    logic [XLEN-1:0] r_regs [NREG];

    logic            r_out_valid;
    logic [31:0]     r_out_inst;
    logic [31:0]     r_out_pc;
    logic [XLEN-1:0] r_out_rdata1;
    logic [XLEN-1:0] r_out_rdata2;
    logic [XLEN-1:0] r_out_imm;
    logic [4:0]      r_out_rd;

    logic [XLEN-1:0] w_lane;
    logic [XLEN-1:0] w_wb_data;
    logic            w_wr_ok;
    logic [6:0]      w_opc;
    logic [4:0]      w_rs1;
    logic [4:0]      w_rs2;
    logic [XLEN-1:0] w_imm;
    logic            w_use_rs1;
    logic            w_use_rs2;
    logic            w_stall;
    logic            w_adv;
    logic [XLEN-1:0] w_rs1_val;
    logic [XLEN-1:0] w_rs2_val;

    assign w_lane  = wb_mem >> {wb_byte_off, 3'b000};
    assign w_wr_ok = wb_en && (wb_rd != 5'd0) && (int'(wb_rd) < NREG);

    // Write-back source select; loads take the shifted lane, LW the raw word.
    always_comb begin
        w_wb_data = '0;
        case (wb_src)
            2'b00: w_wb_data = wb_alu;
            2'b01: begin
                case (wb_funct3)
                    3'b000:  w_wb_data = {{(XLEN-8){w_lane[7]}}, w_lane[7:0]};
                    3'b001:  w_wb_data = {{(XLEN-16){w_lane[15]}}, w_lane[15:0]};
                    3'b010:  w_wb_data = wb_mem;
                    3'b100:  w_wb_data = {{(XLEN-8){1'b0}}, w_lane[7:0]};
                    3'b101:  w_wb_data = {{(XLEN-16){1'b0}}, w_lane[15:0]};
                    default: w_wb_data = '0;
                endcase
            end
            2'b10: w_wb_data = wb_pc4;
            default: w_wb_data = wb_imm;
        endcase
    end

    // Register read: x0 and indices beyond NREG read as zero.
    function automatic logic [XLEN-1:0] f_read(input logic [4:0] idx);
        logic [XLEN-1:0] v;
        v = '0;
        if (idx != 5'd0 && int'(idx) < NREG) begin
            v = r_regs[idx[AW-1:0]];
`ifdef DECODE_BYPASS_EN
            if (w_wr_ok && wb_rd == idx) v = w_wb_data;
`endif
        end
        return v;
    endfunction

    assign w_opc         = in_inst[6:0];
    assign w_rs1         = in_inst[19:15];
    assign w_rs2         = in_inst[24:20];
    assign w_rs1_val     = f_read(w_rs1);
    assign w_rs2_val     = f_read(w_rs2);
    assign ecall_code    = f_read(5'd17);
    assign ecall_a0_data = f_read(5'd10);

    // Immediate formats and register-use flags keyed on opcode.
    always_comb begin
        w_imm     = '0;
        w_use_rs1 = 1'b0;
        w_use_rs2 = 1'b0;
        case (w_opc)
            OPC_OPIMM, OPC_LOAD, OPC_JALR, OPC_SYSTEM: begin
                w_imm     = {{20{in_inst[31]}}, in_inst[31:20]};
                w_use_rs1 = 1'b1;
            end
            OPC_STORE: begin
                w_imm     = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
            end
            OPC_BRANCH: begin
                w_imm     = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
            end
            OPC_OP: begin
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
            end
            OPC_LUI, OPC_AUIPC: w_imm = {in_inst[31:12], 12'b0};
            OPC_JAL: w_imm = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};
            default: w_imm = '0;
        endcase
    end

    assign w_stall  = in_valid && ex_is_load && (ex_rd != 5'd0) &&
                      ((w_use_rs1 && ex_rd == w_rs1) || (w_use_rs2 && ex_rd == w_rs2));
    assign w_adv    = out_ready || !r_out_valid;
    assign in_ready = rstn && (flush || (w_adv && !w_stall));

    // Register file write port; commits even during flush or stall.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
        end else if (w_wr_ok) begin
            r_regs[wb_rd[AW-1:0]] <= w_wb_data;
        end
    end

    // Output slot: flush > bubble on stall > capture; holds when execute is not ready.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_out_valid  <= 1'b0;
            r_out_inst   <= '0;
            r_out_pc     <= '0;
            r_out_rdata1 <= '0;
            r_out_rdata2 <= '0;
            r_out_imm    <= '0;
            r_out_rd     <= '0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
        end else if (w_adv) begin
            if (w_stall) begin
                r_out_valid <= 1'b0;
            end else begin
                r_out_valid  <= in_valid;
                r_out_inst   <= in_inst;
                r_out_pc     <= in_pc;
                r_out_rdata1 <= w_rs1_val;
                r_out_rdata2 <= w_rs2_val;
                r_out_imm    <= w_imm;
                r_out_rd     <= in_inst[11:7];
            end
        end
    end

    assign out_valid  = r_out_valid;
    assign out_inst   = r_out_inst;
    assign out_pc     = r_out_pc;
    assign out_rdata1 = r_out_rdata1;
    assign out_rdata2 = r_out_rdata2;
    assign out_imm    = r_out_imm;
    assign out_rd     = r_out_rd;
endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: a 32-register instance and a 16-register instance
// share every input; expected values are hand-computed constants.
module tb_decode_stage;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn, in_valid, out_ready, flush, ex_is_load, wb_en;
    logic [31:0] in_inst, in_pc;
    logic [4:0]  ex_rd, wb_rd;
    logic [1:0]  wb_src, wb_byte_off;
    logic [2:0]  wb_funct3;
    logic [31:0] wb_alu, wb_mem, wb_pc4, wb_imm;

    logic        in_ready, out_valid;
    logic [31:0] out_inst, out_pc, out_rdata1, out_rdata2, out_imm, ecall_code, ecall_a0_data;
    logic [4:0]  out_rd;

    logic        in_ready_16, out_valid_16;
    logic [31:0] out_inst_16, out_pc_16, out_rdata1_16, out_rdata2_16, out_imm_16;
    logic [31:0] ecall_code_16, ecall_a0_data_16;
    logic [4:0]  out_rd_16;

    int tests = 0;
    int fails = 0;

    decode_stage #(.XLEN(32), .NREG(32)) dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
        .in_inst(in_inst), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
        .out_inst(out_inst), .out_pc(out_pc), .out_rdata1(out_rdata1), .out_rdata2(out_rdata2),
        .out_imm(out_imm), .out_rd(out_rd), .flush(flush), .ex_is_load(ex_is_load),
        .ex_rd(ex_rd), .wb_en(wb_en), .wb_rd(wb_rd), .wb_src(wb_src), .wb_funct3(wb_funct3),
        .wb_byte_off(wb_byte_off), .wb_alu(wb_alu), .wb_mem(wb_mem), .wb_pc4(wb_pc4),
        .wb_imm(wb_imm), .ecall_code(ecall_code), .ecall_a0_data(ecall_a0_data)
    );

    decode_stage #(.XLEN(32), .NREG(16)) dut16 (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready_16),
        .in_inst(in_inst), .in_pc(in_pc), .out_valid(out_valid_16), .out_ready(out_ready),
        .out_inst(out_inst_16), .out_pc(out_pc_16), .out_rdata1(out_rdata1_16),
        .out_rdata2(out_rdata2_16), .out_imm(out_imm_16), .out_rd(out_rd_16), .flush(flush),
        .ex_is_load(ex_is_load), .ex_rd(ex_rd), .wb_en(wb_en), .wb_rd(wb_rd), .wb_src(wb_src),
        .wb_funct3(wb_funct3), .wb_byte_off(wb_byte_off), .wb_alu(wb_alu), .wb_mem(wb_mem),
        .wb_pc4(wb_pc4), .wb_imm(wb_imm), .ecall_code(ecall_code_16),
        .ecall_a0_data(ecall_a0_data_16)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One write-back cycle; unselected sources carry distinct filler values.
    task automatic wb_write(input logic [4:0] rd, input logic [1:0] src, input logic [2:0] f3,
                            input logic [1:0] off, input logic [31:0] val);
        wb_en = 1'b1; wb_rd = rd; wb_src = src; wb_funct3 = f3; wb_byte_off = off;
        wb_alu = 32'hA1A1_A1A1; wb_mem = 32'hB2B2_B2B2; wb_pc4 = 32'hC3C3_C3C3; wb_imm = 32'hD4D4_D4D4;
        case (src)
            2'b00: wb_alu = val;
            2'b01: wb_mem = val;
            2'b10: wb_pc4 = val;
            default: wb_imm = val;
        endcase
        tick();
        wb_en = 1'b0;
    endtask

    task automatic decode(input logic [31:0] inst, input logic [31:0] pc);
        in_valid = 1'b1; in_inst = inst; in_pc = pc;
        tick();
        in_valid = 1'b0;
    endtask

    function automatic logic [31:0] enc_add(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'b0, rs2, rs1, 3'b000, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_addi(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
        return {imm, rs1, 3'b000, rd, 7'b0010011};
    endfunction

    function automatic logic [31:0] enc_sw(input logic [4:0] rs2, input logic [4:0] rs1, input logic [11:0] imm);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
    endfunction

    logic [31:0] inst_sw, inst_addi9, inst_lui, inst_beq, inst_jal, exp_byp;

    initial begin
        rstn = 1'b0; in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0; ex_is_load = 1'b0;
        wb_en = 1'b0; in_inst = '0; in_pc = '0; ex_rd = '0; wb_rd = '0; wb_src = '0;
        wb_byte_off = '0; wb_funct3 = '0; wb_alu = '0; wb_mem = '0; wb_pc4 = '0; wb_imm = '0;
        inst_sw    = enc_sw(5'd7, 5'd2, 12'h000);
        inst_addi9 = enc_addi(5'd9, 5'd0, 12'hFFB);
        inst_lui   = 32'h1234_50B7;
        inst_beq   = {1'b1, 6'b111111, 5'd2, 5'd1, 3'b000, 4'b1100, 1'b1, 7'b1100011};
        inst_jal   = {1'b0, 10'b0, 1'b1, 8'b0, 5'd1, 7'b1101111};
        #1;
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_in_ready", {31'b0, in_ready}, 32'd0);
        check("rst_rdata1", out_rdata1, 32'd0);
        check("rst_ecall", ecall_code, 32'd0);
        tick(); tick();
        rstn = 1'b1;
        #1;
        check("idle_in_ready", {31'b0, in_ready}, 32'd1);

        // Load extension into x5/x6, read back through rs1/rs2.
        wb_write(5'd5, 2'b01, 3'b000, 2'd0, 32'h8000_F0A5);
        decode(enc_add(5'd6, 5'd5, 5'd0), 32'h0000_0100);
        check("lb_off0", out_rdata1, 32'hFFFF_FFA5);
        check("cap_valid", {31'b0, out_valid}, 32'd1);
        check("cap_rd", {27'b0, out_rd}, 32'd6);
        check("cap_pc", out_pc, 32'h0000_0100);
        wb_write(5'd5, 2'b01, 3'b101, 2'd2, 32'h8000_F0A5);
        decode(enc_add(5'd6, 5'd5, 5'd0), 32'h0000_0104);
        check("lhu_off2", out_rdata1, 32'h0000_8000);
        wb_write(5'd5, 2'b01, 3'b001, 2'd0, 32'h8000_F0A5);
        decode(enc_add(5'd6, 5'd5, 5'd0), 32'h0000_0108);
        check("lh_off0", out_rdata1, 32'hFFFF_F0A5);
        wb_write(5'd6, 2'b01, 3'b100, 2'd1, 32'h8000_F0A5);
        decode(enc_add(5'd7, 5'd6, 5'd0), 32'h0000_010C);
        check("lbu_off1", out_rdata1, 32'h0000_00F0);
        wb_write(5'd6, 2'b01, 3'b011, 2'd0, 32'h8000_F0A5);
        decode(enc_add(5'd7, 5'd6, 5'd0), 32'h0000_0110);
        check("bad_funct3", out_rdata1, 32'd0);
        wb_write(5'd0, 2'b01, 3'b010, 2'd0, 32'h8000_F0A5);
        decode(enc_add(5'd7, 5'd0, 5'd5), 32'h0000_0114);
        check("x0_zero", out_rdata1, 32'd0);
        check("rs2_x5", out_rdata2, 32'hFFFF_F0A5);

        // PC+4 and immediate sources via the ecall taps; NREG=16 has no x17 or x20.
        wb_write(5'd10, 2'b10, 3'b000, 2'd0, 32'h0000_1004);
        check("a0_pc4", ecall_a0_data, 32'h0000_1004);
        wb_write(5'd17, 2'b11, 3'b000, 2'd0, 32'h0000_005D);
        check("a7_imm", ecall_code, 32'h0000_005D);
        check("a7_nreg16", ecall_code_16, 32'd0);
        wb_write(5'd20, 2'b00, 3'b000, 2'd0, 32'hCAFE_0020);
        decode(enc_add(5'd6, 5'd20, 5'd0), 32'h0000_0118);
        check("x20_nreg32", out_rdata1, 32'hCAFE_0020);
        check("x20_nreg16", out_rdata1_16, 32'd0);

        // Same-cycle write and read of x3.
        wb_write(5'd3, 2'b00, 3'b000, 2'd0, 32'h0000_1111);
`ifdef DECODE_BYPASS_EN
        exp_byp = 32'h0000_1234;
`else
        exp_byp = 32'h0000_1111;
`endif
        wb_en = 1'b1; wb_rd = 5'd3; wb_src = 2'b00; wb_alu = 32'h0000_1234;
        decode(enc_add(5'd4, 5'd3, 5'd3), 32'h0000_011C);
        wb_en = 1'b0;
        check("byp_rdata1", out_rdata1, exp_byp);
        check("byp_rdata2", out_rdata2, exp_byp);
        decode(enc_add(5'd4, 5'd3, 5'd0), 32'h0000_0120);
        check("after_byp", out_rdata1, 32'h0000_1234);

        // Load-use stall on rs2 of a store, with a write-back of x7 during the stall.
        in_valid = 1'b1; in_inst = inst_sw; in_pc = 32'h0000_0124; ex_is_load = 1'b1; ex_rd = 5'd7;
        #1;
        check("stall_in_ready", {31'b0, in_ready}, 32'd0);
        tick();
        check("stall_bubble", {31'b0, out_valid}, 32'd0);
        wb_en = 1'b1; wb_rd = 5'd7; wb_src = 2'b00; wb_alu = 32'h0000_0077;
        tick();
        wb_en = 1'b0;
        check("stall_wb_bubble", {31'b0, out_valid}, 32'd0);
        ex_is_load = 1'b0;
        #1;
        check("unstall_in_ready", {31'b0, in_ready}, 32'd1);
        tick();
        check("unstall_valid", {31'b0, out_valid}, 32'd1);
        check("unstall_inst", out_inst, inst_sw);
        check("unstall_rs2", out_rdata2, 32'h0000_0077);
        in_inst = enc_addi(5'd8, 5'd2, 12'h007); ex_is_load = 1'b1; ex_rd = 5'd7;
        #1;
        check("no_stall_imm_field", {31'b0, in_ready}, 32'd1);
        ex_is_load = 1'b0; in_valid = 1'b0;

        // Backpressure, then flush with a concurrent write-back.
        decode(inst_addi9, 32'h0000_0200);
        check("addi_imm", out_imm, 32'hFFFF_FFFB);
        out_ready = 1'b0; in_valid = 1'b1; in_inst = inst_lui; in_pc = 32'h0000_0204;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("hold_in_ready", {31'b0, in_ready}, 32'd0);
            tick();
            check("hold_inst", out_inst, inst_addi9);
            check("hold_valid", {31'b0, out_valid}, 32'd1);
        end
        flush = 1'b1;
        wb_en = 1'b1; wb_rd = 5'd10; wb_src = 2'b10; wb_pc4 = 32'h0000_2222;
        #1;
        check("flush_in_ready", {31'b0, in_ready}, 32'd1);
        tick();
        flush = 1'b0; wb_en = 1'b0;
        check("flush_valid", {31'b0, out_valid}, 32'd0);
        check("flush_wb_commit", ecall_a0_data, 32'h0000_2222);
        tick();
        check("lui_imm", out_imm, 32'h1234_5000);
        check("lui_rd", {27'b0, out_rd}, 32'd1);
        out_ready = 1'b1; in_valid = 1'b0;

        // Remaining immediate formats.
        decode(inst_beq, 32'h0000_0300);
        check("beq_imm", out_imm, 32'hFFFF_FFF8);
        decode(inst_jal, 32'h0000_0304);
        check("jal_imm", out_imm, 32'h0000_0800);
        decode(enc_sw(5'd3, 5'd1, 12'hFFC), 32'h0000_0308);
        check("sw_imm", out_imm, 32'hFFFF_FFFC);
        decode(32'hFFFF_FF0B, 32'h0000_030C);
        check("unknown_imm", out_imm, 32'd0);
        tick();
        check("capture_invalid", {31'b0, out_valid}, 32'd0);

        // Asynchronous reset in the middle of a cycle.
        in_valid = 1'b1; in_inst = enc_addi(5'd1, 5'd5, 12'h001); in_pc = 32'h0000_0400;
        tick();
        check("pre_rst_rdata1", out_rdata1, 32'hFFFF_F0A5);
        #3;
        rstn = 1'b0;
        #1;
        check("mid_rst_valid", {31'b0, out_valid}, 32'd0);
        check("mid_rst_rdata1", out_rdata1, 32'd0);
        check("mid_rst_ecall", ecall_code, 32'd0);
        check("mid_rst_in_ready", {31'b0, in_ready}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
